// File: rtl/fft_rx_pkg.sv
// Shared types for the RX FFT front end: sample word, write-sequencer states, bank states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fft_rx_pkg;

    localparam int DATA_W_DEFAULT   = 32;
    localparam int N_POINTS_DEFAULT = 16;

    // One complex sample: I in the upper half, Q in the lower half.
    typedef logic signed [DATA_W_DEFAULT-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WAIT_BANK
    } wr_state_e;

    typedef enum logic {
        EMPTY,
        FULL
    } bank_state_e;

endpackage

// File: rtl/fft16_bank_tracker.sv
// Two-bank occupancy tracker: FULL flags, read pointer and the frame offer to the FFT.
// Latency: a flag set at edge n is offered on frame_valid_o from edge n+1; a take frees the bank at the same edge.
// Backpressure: frame_valid_o holds until fft_ready_i; banks are offered strictly in alternating fill order.
module fft16_bank_tracker
    import fft_rx_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       set_full_i,
    input  logic       set_bank_i,
    input  logic       fft_ready_i,
    output logic       frame_valid_o,
    output logic       rd_bank_o,
    output logic       take_o,
    output logic [1:0] bank_full_o
);

    bank_state_e bank_q [2];
    logic        rd_bank_q;
    logic        frame_valid_q;
    logic        take;

    // Handshake and flag decode for the write sequencer.
    always_comb begin
        take           = frame_valid_q && fft_ready_i;
        bank_full_o[0] = (bank_q[0] == FULL);
        bank_full_o[1] = (bank_q[1] == FULL);
    end

    // Offer uses flags as they stood before this edge: the bank just taken is never re-offered,
    // and a freshly completed bank is offered one cycle after its flag becomes visible.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bank_q[0]     <= EMPTY;
            bank_q[1]     <= EMPTY;
            rd_bank_q     <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            if (set_full_i) begin
                bank_q[set_bank_i] <= FULL;
            end
            if (take) begin
                bank_q[rd_bank_q] <= EMPTY;
                rd_bank_q         <= !rd_bank_q;
                frame_valid_q     <= (bank_q[!rd_bank_q] == FULL);
            end else begin
                frame_valid_q     <= (bank_q[rd_bank_q] == FULL);
            end
        end
    end

    assign frame_valid_o = frame_valid_q;
    assign rd_bank_o     = rd_bank_q;
    assign take_o        = take;

endmodule

// File: rtl/fft16_frame_ctrl.sv
// Loads sample pairs into a two-bank FFT input buffer, aligned on start-of-symbol, and offers full banks.
// Latency: write strobe/bank/addr/data 1 cycle after acceptance; frame offered 2 cycles after the final acceptance.
// Backpressure: o_ready drops while the next bank is still FULL; o_frame_valid holds until i_fft_ready.
module fft16_frame_ctrl
    import fft_rx_pkg::*;
#(
    parameter int  DOUBLE_DATA_WIDTH = DATA_W_DEFAULT,
    parameter int  N_POINTS          = N_POINTS_DEFAULT,
    localparam int ADDR_W            = $clog2(N_POINTS)
) (
    input  logic                         clk,
    input  logic                         i_rst_n,
    input  logic                         i_valid,
    input  logic                         i_sof,
    input  logic [DOUBLE_DATA_WIDTH-1:0] i1_data,
    input  logic [DOUBLE_DATA_WIDTH-1:0] i2_data,
    output logic                         o_ready,
    output logic                         o_wr_en,
    output logic                         o_wr_bank,
    output logic [ADDR_W-1:0]            o_wr_addr,
    output logic [DOUBLE_DATA_WIDTH-1:0] o_wr_data1,
    output logic [DOUBLE_DATA_WIDTH-1:0] o_wr_data2,
    output logic                         o_frame_valid,
    output logic                         o_rd_bank,
    input  logic                         i_fft_ready,
    output logic                         o_sof_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_POINTS - 2);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(2);

    wr_state_e                    state_q;
    logic                         wr_bank_q;
    logic [ADDR_W-1:0]            addr_q;
    logic                         ready_q;
    logic                         wr_en_q;
    logic                         wr_bank_out_q;
    logic [ADDR_W-1:0]            wr_addr_q;
    logic [DOUBLE_DATA_WIDTH-1:0] wr_data1_q;
    logic [DOUBLE_DATA_WIDTH-1:0] wr_data2_q;
    logic                         sof_err_q;

    logic       accept;
    logic       wr_fire;
    logic       restart;
    logic       frame_done;
    logic       next_bank_free;
    logic       take;
    logic       rd_bank;
    logic       frame_valid;
    logic [1:0] bank_full;

    fft16_bank_tracker u_bank_tracker (
        .clk_i         (clk),
        .rst_n_i       (i_rst_n),
        .set_full_i    (frame_done),
        .set_bank_i    (wr_bank_q),
        .fft_ready_i   (i_fft_ready),
        .frame_valid_o (frame_valid),
        .rd_bank_o     (rd_bank),
        .take_o        (take),
        .bank_full_o   (bank_full)
    );

    // Acceptance decode; the bank after the current one counts as free if the FFT releases it this very edge.
    always_comb begin
        accept         = i_valid && ready_q;
        wr_fire        = accept && (i_sof || (state_q == FILL));
        restart        = accept && i_sof && (state_q == FILL);
        frame_done     = accept && !i_sof && (state_q == FILL) && (addr_q == LAST_ADDR);
        next_bank_free = !bank_full[!wr_bank_q] || (take && (rd_bank != wr_bank_q));
    end

    // Write sequencer with registered ready, write port and restart pulse.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            wr_bank_q     <= 1'b0;
            addr_q        <= '0;
            ready_q       <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_bank_out_q <= 1'b0;
            wr_addr_q     <= '0;
            wr_data1_q    <= '0;
            wr_data2_q    <= '0;
            sof_err_q     <= 1'b0;
        end else begin
            wr_en_q   <= wr_fire;
            sof_err_q <= restart;
            if (wr_fire) begin
                wr_bank_out_q <= wr_bank_q;
                wr_addr_q     <= i_sof ? '0 : addr_q;
                wr_data1_q    <= i1_data;
                wr_data2_q    <= i2_data;
            end

            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept && i_sof) begin
                        state_q <= FILL;
                        addr_q  <= ADDR_STEP;
                    end
                end
                FILL: begin
                    if (accept) begin
                        if (i_sof) begin
                            // Partial frame abandoned; restart in place in the same bank.
                            addr_q <= ADDR_STEP;
                        end else if (addr_q == LAST_ADDR) begin
                            wr_bank_q <= !wr_bank_q;
                            addr_q    <= '0;
                            if (next_bank_free) begin
                                state_q <= IDLE;
                                ready_q <= 1'b1;
                            end else begin
                                state_q <= WAIT_BANK;
                                ready_q <= 1'b0;
                            end
                        end else begin
                            addr_q <= addr_q + ADDR_STEP;
                        end
                    end
                end
                WAIT_BANK: begin
                    if (!bank_full[wr_bank_q]) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready       = ready_q;
    assign o_wr_en       = wr_en_q;
    assign o_wr_bank     = wr_bank_out_q;
    assign o_wr_addr     = wr_addr_q;
    assign o_wr_data1    = wr_data1_q;
    assign o_wr_data2    = wr_data2_q;
    assign o_sof_err     = sof_err_q;
    assign o_frame_valid = frame_valid;
    assign o_rd_bank     = rd_bank;

endmodule

// File: doc/fft16_frame_ctrl.md
Name: fft16_frame_ctrl

Overview:
- Sequencer that loads complex samples into a two-bank FFT16 input buffer and schedules banks to the FFT.
- Sits in the RX chain between the serial-to-parallel sample path (two complex samples per clock) and the FFT16 core.
- Accepts sample pairs under a valid/ready handshake and aligns frames on a start-of-symbol marker.
- Generates bank/address/write strobes, and offers full banks to the FFT with a valid/ready handshake.

Parameters:
- DOUBLE_DATA_WIDTH, 32: width of one complex sample, 16-bit I in [31:16] and 16-bit Q in [15:0].
- N_POINTS, 16: FFT size in complex samples; must be even and ≥4.
- ADDR_W, $clog2(N_POINTS): derived; must not be overridden.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  a sample pair is present on i1_data/i2_data.
- i_sof  in  1  qualifies the pair as the first pair of a symbol.
- i1_data  in  DOUBLE_DATA_WIDTH  even-index sample (signed).
- i2_data  in  DOUBLE_DATA_WIDTH  odd-index sample (signed).
- o_ready  out  1  the controller accepts a pair this cycle.
- o_wr_en  out  1  buffer write strobe; writes two slots.
- o_wr_bank  out  1  target bank.
- o_wr_addr  out  ADDR_W  even slot index; the pair goes to addr and addr+1.
- o_wr_data1  out  DOUBLE_DATA_WIDTH  data for slot addr.
- o_wr_data2  out  DOUBLE_DATA_WIDTH  data for slot addr+1.
- o_frame_valid  out  1  bank o_rd_bank holds a complete frame.
- o_rd_bank  out  1  bank offered to the FFT.
- i_fft_ready  in  1  the FFT takes the offered frame when o_frame_valid is high.
- o_sof_err  out  1  one-cycle pulse: a symbol was restarted mid-frame.

Behaviour:
- Reset values:
  - All outputs 0.
  - Both banks EMPTY; wr_bank=0, rd_bank=0.
  - Write FSM in IDLE.
  - Reset asserted mid-frame discards partial and full frames alike.
- Accept rule: a pair is accepted when i_valid && o_ready.
- Write FSM states:
  - IDLE: o_ready=1.
    - Accepted pair with i_sof=0 is dropped: no write, no error.
    - Accepted pair with i_sof=1 is written to addr 0; go to FILL with next addr 2.
  - FILL: o_ready=1.
    - Each accepted pair is written at the current addr; addr advances by 2.
    - Accepted pair with i_sof=1: pulse o_sof_err; the pair is written to addr 0 of the same bank and next addr is 2. The partial frame is abandoned.
    - Pair accepted at addr N_POINTS-2 completes the frame: mark wr_bank FULL, then toggle wr_bank.
      - If the new wr_bank is EMPTY, go to IDLE.
      - Otherwise go to WAIT_BANK.
  - WAIT_BANK: o_ready=0. Go to IDLE the cycle after wr_bank becomes EMPTY.
- Write timing:
  - Write strobe, bank, addr and both data words are registered: they appear exactly 1 cycle after acceptance.
  - No write strobe is ever issued for a dropped pair.
- FULL flag timing: the flag is set in the same cycle o_wr_en is asserted for the final pair. o_frame_valid therefore rises 1 cycle after the final write (2 cycles after the final acceptance).
- Read side:
  - o_frame_valid = FULL[rd_bank], driven from a register.
  - On o_frame_valid && i_fft_ready: rd_bank becomes EMPTY and rd_bank toggles, both visible next cycle.
  - o_frame_valid must hold until taken.
- Simultaneous events:
  - A frame completing in one bank while the other bank is freed in the same cycle: both updates take effect. The FSM goes to IDLE, not WAIT_BANK.
  - A bank is never written while FULL.
  - Banks are consumed strictly in fill order.
- Throughput: sustained 1 pair/clock when the FFT takes each frame within N_POINTS/2 cycles; no bubbles between frames.

Decomposition:
- Shared package fft_rx_pkg:
  - sample typedef, logic signed [DOUBLE_DATA_WIDTH-1:0].
  - Write-FSM state enum {IDLE, FILL, WAIT_BANK}.
  - Bank-state enum {EMPTY, FULL}.
  - N_POINTS default constant.
- One natural sub-module, fft16_bank_tracker: the two FULL flags, rd_bank pointer and read handshake.
- The write FSM, address counter and output registers stay in the top module.

Test Plan:
- Basic fill: reset, then 8 consecutive pairs, first with i_sof=1, data k=0..15, i_fft_ready=1.
  - 8 writes to bank 0 at addr 0,2,…,14 with data k,k+1, each 1 cycle after acceptance.
  - o_frame_valid high 2 cycles after the 8th acceptance for 1 cycle; o_rd_bank=0.
- Pre-SOF drop: 3 pairs with i_sof=0, then a frame.
  - No o_wr_en for the first 3 pairs; the frame lands at addr 0..14 as in the basic fill.
- Mid-frame restart: i_sof=1 on the 5th pair.
  - o_sof_err pulses once; that pair is written at addr 0 of bank 0.
  - The frame completes 7 pairs later.
- Backpressure: i_fft_ready=0, stream 3 full frames back-to-back.
  - Banks 0 and 1 go FULL; o_ready falls after the 16th pair.
  - No writes occur while stalled.
  - Raise i_fft_ready for 1 cycle: bank 0 is freed, o_ready returns the following cycle, and the third frame goes to bank 0.
- Same-cycle free and complete: the FFT takes bank 0 in the same cycle the bank-1 final pair is accepted.
  - The FSM goes to IDLE; o_ready stays 1; o_rd_bank=1 next cycle.
- Reset mid-frame: assert i_rst_n=0 after 4 pairs.
  - All outputs 0, both banks EMPTY.
  - The next SOF frame writes bank 0 from addr 0.
